array2d_fill_lanes: RTL and testbench
=====================================

# array2d_fill_lanes

Parametrised 2D array loader for the openCV pipeline. It reads a header of width and height from a 32-bit input word stream, then writes the frame into a 2D buffer at LANES pixels per beat, with per-lane write masks for ragged row tails. It validates header dimensions against compile-time limits, supports single-shot or auto-rearm frame modes, and counts completed frames. It sits between the host/DMA word port and the image line buffers.

## Interface
- ROW_WIDTH, 10: width of column address waddrX and of stored width.
- COL_WIDTH, 10: width of row address waddrY and of stored height.
- WORD_SIZE, 8: bits per pixel.
- LANES, 1: pixels per input word; LANES*WORD_SIZE ≤ 32; LANES ∈ {1,2,4}.
- MAX_W, 640: largest accepted width (≤ 2^ROW_WIDTH−1).
- MAX_H, 480: largest accepted height (≤ 2^COL_WIDTH−1).
- AUTO_REARM, 0: 1 = return to header read after each frame without start.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; rearms from S_Done/S_Error.
- data_wanted  out  1  block can accept a word this cycle.
- data_ready  in  1  word present on data; transfer = data_wanted && data_ready.
- data  in  32  header or packed pixels, lane i = data[i*WORD_SIZE +: WORD_SIZE].
- we  out  1  write strobe.
- q  out  LANES*WORD_SIZE  write data = data[LANES*WORD_SIZE-1:0].
- wmask  out  LANES  per-lane write enable.
- waddrX  out  ROW_WIDTH  column of lane 0.
- waddrY  out  COL_WIDTH  row.
- loaded  out  1  frame complete (level).
- error  out  1  header rejected (level).
- frame_cnt  out  16  completed frames, wraps at 2^16.

## Operation
- States: S_ReadWidth, S_ReadHeight, S_ReadData, S_Done, S_Error.
- Reset: state S_ReadWidth; waddrX, waddrY, sizeWidth, sizeHeight, loaded, error, frame_cnt all 0.
- S_ReadWidth: on transfer, capture data; if data==0 or data>MAX_W → S_Error, else sizeWidth←data[ROW_WIDTH-1:0], → S_ReadHeight.
- S_ReadHeight: same against MAX_H into sizeHeight; success → S_ReadData with waddrX=waddrY=0.
- S_ReadData: on transfer: if waddrX+LANES < sizeWidth, waddrX += LANES; else waddrX←0, waddrY += 1, and if waddrY+1==sizeHeight → loaded←1, frame_cnt += 1, → S_Done.
- Address arithmetic computed at ROW_WIDTH+1 / COL_WIDTH+1 bits; no overflow at MAX limits.
- wmask[i] = (waddrX+i < sizeWidth); full mask except on last beat of a row when sizeWidth mod LANES ≠ 0.
- S_Done: data_wanted=0; if AUTO_REARM or start → S_ReadWidth next cycle, loaded←0, addresses cleared.
- S_Error: error=1, data_wanted=0; start → S_ReadWidth, error←0. AUTO_REARM does not leave S_Error.
- start ignored in S_ReadWidth/S_ReadHeight/S_ReadData.
- data_wanted = state ∈ {S_ReadWidth, S_ReadHeight, S_ReadData}.
- we = data_ready && state==S_ReadData (combinational, same cycle as word).

## Timing
- Header: 2 transfers minimum; first pixel word may transfer the cycle after height accepted.
- Pixel write: zero latency; we, q, wmask, waddrX/Y valid in the transfer cycle; address updates on that edge.
- One pixel word per cycle sustained; data_ready low stalls with no state change.
- loaded and frame_cnt update on the edge ending the last transfer; data_wanted drops the next cycle.
- AUTO_REARM: exactly one cycle in S_Done (loaded high one cycle), then S_ReadWidth.
- Reset mid-frame: immediate async clear of all outputs and state; partial frame discarded, frame_cnt not incremented.
- Frame of ceil(W/LANES)*H pixel beats plus 2 header beats.

## Test plan
- LANES=1, W=4,H=3, continuous data_ready: 12 writes, addresses (0,0)…(3,2) in order, loaded=1 after 12th, frame_cnt=1, data_wanted=0.
- LANES=4, W=10,H=2: per row beats at waddrX 0,4,8; wmask 1111,1111,0011; 6 writes total, loaded after 6th.
- Header width=0 then width=641 (MAX_W=640): each → error=1, data_wanted=0; start clears error and re-reads width.
- Random data_ready gaps (50%) with W=5,H=5: we only on transfers, 25 writes, addresses match ideal order.
- AUTO_REARM=1, three back-to-back 2×2 frames: loaded pulses 3 times one cycle each, frame_cnt=3.
- Reset asserted after 7 of 12 beats: all outputs 0 immediately; following full 4×3 frame loads correctly, frame_cnt=1.

Source files
------------

// File: rtl/array2d_fill_lanes.sv
// -----------------------------------------------------------------------------
// array2d_fill_lanes
//   Loads a frame from a 32-bit word stream into a 2D buffer. The first two
//   accepted words carry width and height. Both are checked against MAX_W and
//   MAX_H. Every word after that carries LANES packed pixels. Each pixel word
//   is written in the same cycle it is transferred. The per-lane mask blanks
//   the lanes that lie past the right edge of the frame. The block either waits
//   for start after each frame or, when AUTO_REARM is set, goes straight back
//   to reading a new header.
//
// Ports
//   clk          clock, all state on rising edge
//   reset        asynchronous, active-high reset
//   start        one-cycle pulse, rearms from S_Done / S_Error
//   data_wanted  block can accept a word this cycle
//   data_ready   word present on data (transfer = data_wanted && data_ready)
//   data         header word or packed pixels, lane i = data[i*WORD_SIZE +: WORD_SIZE]
//   we           write strobe (combinational, transfer cycle)
//   q            write data = data[LANES*WORD_SIZE-1:0]
//   wmask        per-lane write enable
//   waddrX       column of lane 0
//   waddrY       row
//   loaded       frame complete (level)
//   error        header rejected (level)
//   frame_cnt    completed frames, wraps at 2^16
// -----------------------------------------------------------------------------
module array2d_fill_lanes #(
    parameter int ROW_WIDTH  = 10,
    parameter int COL_WIDTH  = 10,
    parameter int WORD_SIZE  = 8,
    parameter int LANES      = 1,
    parameter int MAX_W      = 640,
    parameter int MAX_H      = 480,
    parameter int AUTO_REARM = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         data_wanted,
    input  logic                         data_ready,
    input  logic [31:0]                  data,
    output logic                         we,
    output logic [LANES*WORD_SIZE-1:0]   q,
    output logic [LANES-1:0]             wmask,
    output logic [ROW_WIDTH-1:0]         waddrX,
    output logic [COL_WIDTH-1:0]         waddrY,
    output logic                         loaded,
    output logic                         error,
    output logic [15:0]                  frame_cnt
);

    localparam int DW = LANES * WORD_SIZE;
    localparam int XW = ROW_WIDTH + 1;
    localparam int YW = COL_WIDTH + 1;

    typedef enum logic [2:0] {
        S_ReadWidth,
        S_ReadHeight,
        S_ReadData,
        S_Done,
        S_Error
    } state_t;

    state_t state, state_next;

    logic [ROW_WIDTH-1:0] size_width;
    logic [COL_WIDTH-1:0] size_height;

    logic          hdr_bad_w;
    logic          hdr_bad_h;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_next;
    logic          row_end;
    logic          frame_end;

    // The header is judged on the whole 32-bit word. A value above the limit
    // must not slip through just because its low bits would look legal.
    assign hdr_bad_w = (data == 32'd0) || (data > 32'(MAX_W));
    assign hdr_bad_h = (data == 32'd0) || (data > 32'(MAX_H));

    // One extra bit so the step past the right and bottom edges never wraps.
    assign x_next    = {1'b0, waddrX} + XW'(LANES);
    assign y_next    = {1'b0, waddrY} + YW'(1);
    assign row_end   = !(x_next < {1'b0, size_width});
    assign frame_end = row_end && (y_next == {1'b0, size_height});

    assign q = data[DW-1:0];

    always_comb begin
        wmask = '0;
        for (int i = 0; i < LANES; i++) begin
            wmask[i] = ({1'b0, waddrX} + XW'(i)) < {1'b0, size_width};
        end
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
        state_next  = state;
        data_wanted = 1'b0;
        we          = 1'b0;
        unique case (state)
            S_ReadWidth: begin
                data_wanted = 1'b1;
                if (data_ready) state_next = hdr_bad_w ? S_Error : S_ReadHeight;
            end
            S_ReadHeight: begin
                data_wanted = 1'b1;
                if (data_ready) state_next = hdr_bad_h ? S_Error : S_ReadData;
            end
            S_ReadData: begin
                data_wanted = 1'b1;
                we          = data_ready;
                if (data_ready && frame_end) state_next = S_Done;
            end
            S_Done: begin
                if ((AUTO_REARM != 0) || start) state_next = S_ReadWidth;
            end
            S_Error: begin
                // Only an explicit start leaves a rejected header.
                if (start) state_next = S_ReadWidth;
            end
            default: state_next = S_ReadWidth;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_ReadWidth;
            waddrX      <= '0;
            waddrY      <= '0;
            size_width  <= '0;
            size_height <= '0;
            loaded      <= 1'b0;
            error       <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                S_ReadWidth: begin
                    if (data_ready) begin
                        if (hdr_bad_w) error      <= 1'b1;
                        else           size_width <= data[ROW_WIDTH-1:0];
                    end
                end
                S_ReadHeight: begin
                    if (data_ready) begin
                        if (hdr_bad_h) begin
                            error <= 1'b1;
                        end else begin
                            size_height <= data[COL_WIDTH-1:0];
                            waddrX      <= '0;
                            waddrY      <= '0;
                        end
                    end
                end
                S_ReadData: begin
                    if (data_ready) begin
                        if (!row_end) begin
                            waddrX <= x_next[ROW_WIDTH-1:0];
                        end else begin
                            waddrX <= '0;
                            waddrY <= y_next[COL_WIDTH-1:0];
                            if (frame_end) begin
                                loaded    <= 1'b1;
                                frame_cnt <= frame_cnt + 16'd1;
                            end
                        end
                    end
                end
                S_Done: begin
                    if (state_next == S_ReadWidth) begin
                        loaded <= 1'b0;
                        waddrX <= '0;
                        waddrY <= '0;
                    end
                end
                S_Error: begin
                    if (start) error <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_array2d_fill_lanes.sv
// -----------------------------------------------------------------------------
// tb_array2d_fill_lanes
//   Four instances of array2d_fill_lanes share one clock and data bus:
//     0: LANES=1            1: LANES=4
//     2: LANES=1 AUTO_REARM 3: LANES=2
//   sel routes start/data_ready to one instance and muxes its outputs back.
//   Expected pixel beats come from a row/column walk of the frame.
// -----------------------------------------------------------------------------
module tb_array2d_fill_lanes;

    localparam int N_DUT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N_DUT-1:0] reset_v;
    logic             start;
    logic             data_ready;
    logic [31:0]      data;
    logic [1:0]       sel;
    logic [N_DUT-1:0] start_v;
    logic [N_DUT-1:0] ready_v;

    always_comb begin
        for (int k = 0; k < N_DUT; k++) begin
            start_v[k] = start && (sel == 2'(k));
            ready_v[k] = data_ready && (sel == 2'(k));
        end
    end

    logic        dw_v [N_DUT];
    logic        we_v [N_DUT];
    logic        ld_v [N_DUT];
    logic        er_v [N_DUT];
    logic [9:0]  x_v  [N_DUT];
    logic [9:0]  y_v  [N_DUT];
    logic [15:0] fc_v [N_DUT];
    logic [7:0]  q0;  logic [0:0] wm0;
    logic [31:0] q1;  logic [3:0] wm1;
    logic [7:0]  q2;  logic [0:0] wm2;
    logic [15:0] q3;  logic [1:0] wm3;

    array2d_fill_lanes #(.LANES(1), .AUTO_REARM(0)) dut0 (
        .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .data_wanted(dw_v[0]),
        .data_ready(ready_v[0]), .data(data), .we(we_v[0]), .q(q0), .wmask(wm0),
        .waddrX(x_v[0]), .waddrY(y_v[0]), .loaded(ld_v[0]), .error(er_v[0]), .frame_cnt(fc_v[0]));
    array2d_fill_lanes #(.LANES(4), .AUTO_REARM(0)) dut1 (
        .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .data_wanted(dw_v[1]),
        .data_ready(ready_v[1]), .data(data), .we(we_v[1]), .q(q1), .wmask(wm1),
        .waddrX(x_v[1]), .waddrY(y_v[1]), .loaded(ld_v[1]), .error(er_v[1]), .frame_cnt(fc_v[1]));
    array2d_fill_lanes #(.LANES(1), .AUTO_REARM(1)) dut2 (
        .clk(clk), .reset(reset_v[2]), .start(start_v[2]), .data_wanted(dw_v[2]),
        .data_ready(ready_v[2]), .data(data), .we(we_v[2]), .q(q2), .wmask(wm2),
        .waddrX(x_v[2]), .waddrY(y_v[2]), .loaded(ld_v[2]), .error(er_v[2]), .frame_cnt(fc_v[2]));
    array2d_fill_lanes #(.LANES(2), .AUTO_REARM(0)) dut3 (
        .clk(clk), .reset(reset_v[3]), .start(start_v[3]), .data_wanted(dw_v[3]),
        .data_ready(ready_v[3]), .data(data), .we(we_v[3]), .q(q3), .wmask(wm3),
        .waddrX(x_v[3]), .waddrY(y_v[3]), .loaded(ld_v[3]), .error(er_v[3]), .frame_cnt(fc_v[3]));

    logic        o_dw, o_we, o_ld, o_er;
    logic [9:0]  o_x, o_y;
    logic [15:0] o_fc;
    logic [31:0] o_q;
    logic [3:0]  o_wm;

    always_comb begin
        o_dw = dw_v[sel];
        o_we = we_v[sel];
        o_ld = ld_v[sel];
        o_er = er_v[sel];
        o_x  = x_v[sel];
        o_y  = y_v[sel];
        o_fc = fc_v[sel];
        o_q  = '0;
        o_wm = '0;
        case (sel)
            2'd0: begin o_q[7:0]  = q0; o_wm[0]   = wm0[0]; end
            2'd1: begin o_q       = q1; o_wm      = wm1;    end
            2'd2: begin o_q[7:0]  = q2; o_wm[0]   = wm2[0]; end
            default: begin o_q[15:0] = q3; o_wm[1:0] = wm3; end
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt [N_DUT];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d, t=%0t): got %0h, expected %0h", name, sel, $time, act, exp);
        end
    endtask

    function automatic int lanes_of(input logic [1:0] k);
        case (k)
            2'd1:    return 4;
            2'd3:    return 2;
            default: return 1;
        endcase
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int k);
        reset_v[k] = 1'b1;
        next_cycle();
        reset_v[k] = 1'b0;
        exp_cnt[k] = 0;
    endtask

    task automatic send_header(input int w, input int h, input int pct);
        logic [31:0] words [2];
        words[0] = 32'(w);
        words[1] = 32'(h);
        for (int i = 0; i < 2; i++) begin
            bit sent = 1'b0;
            int budget = 200;
            while (!sent && budget > 0) begin
                data       = words[i];
                data_ready = ($urandom_range(99) < pct);
                @(negedge clk);
                if (data_ready) begin
                    check("hdr_wanted", o_dw, 1);
                    sent = 1'b1;
                end
                next_cycle();
                budget--;
            end
            check("hdr_sent", sent, 1);
        end
        data_ready = 1'b0;
    endtask

    typedef struct {
        int         x;
        int         y;
        logic [3:0] m;
    } beat_t;

    // Sends a whole frame and checks each write against the ideal raster walk.
    task automatic run_frame(input int w, input int h, input int pct);
        beat_t       exp_q [$];
        beat_t       e;
        int          ln = lanes_of(sel);
        int          budget;
        logic [31:0] qmask;
        qmask = (ln == 4) ? 32'hFFFF_FFFF : ((32'd1 << (ln * 8)) - 32'd1);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x += ln) begin
                e.x = x;
                e.y = y;
                e.m = '0;
                for (int i = 0; i < ln; i++) e.m[i] = (x + i < w);
                exp_q.push_back(e);
            end
        end
        send_header(w, h, pct);
        budget = exp_q.size() * 20 + 100;
        while (exp_q.size() > 0 && budget > 0) begin
            data_ready = ($urandom_range(99) < pct);
            data       = $urandom;
            @(negedge clk);
            check("px_wanted", o_dw, 1);
            check("px_we", o_we, data_ready);
            if (data_ready) begin
                e = exp_q.pop_front();
                check("px_x", o_x, 64'(e.x));
                check("px_y", o_y, 64'(e.y));
                check("px_wmask", o_wm, e.m);
                check("px_q", o_q, data & qmask);
            end
            next_cycle();
            budget--;
        end
        check("px_all_written", 64'(exp_q.size()), 0);
        data_ready = 1'b0;
        exp_cnt[sel]++;
        @(negedge clk);
        check("done_loaded", o_ld, 1);
        check("done_wanted", o_dw, 0);
        check("done_we", o_we, 0);
        check("done_frame_cnt", o_fc, 64'(16'(exp_cnt[sel])));
        next_cycle();
    endtask

    // Non-rearming instance: sits in S_Done ignoring words until start.
    task automatic rearm();
        data_ready = 1'b1;
        data       = 32'd4;
        repeat (2) begin
            @(negedge clk);
            check("hold_loaded", o_ld, 1);
            check("hold_wanted", o_dw, 0);
            check("hold_we", o_we, 0);
            next_cycle();
        end
        data_ready = 1'b0;
        start      = 1'b1;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        check("rearm_loaded", o_ld, 0);
        check("rearm_wanted", o_dw, 1);
        check("rearm_x", o_x, 0);
        check("rearm_y", o_y, 0);
        next_cycle();
    endtask

    typedef struct {
        logic [31:0] w;
        logic [31:0] h;
        bit          err;
    } hdr_vec_t;

    hdr_vec_t tbl [9];

    int ld_pulses = 0;
    bit ar_mon    = 1'b0;
    always @(negedge clk) begin
        if (ar_mon && o_ld) ld_pulses <= ld_pulses + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'd0,         32'd5,         1'b1};
        tbl[1] = '{32'd641,       32'd5,         1'b1};
        tbl[2] = '{32'd640,       32'd0,         1'b1};
        tbl[3] = '{32'd640,       32'd481,       1'b1};
        tbl[4] = '{32'd640,       32'd480,       1'b0};
        tbl[5] = '{32'd1,         32'd1,         1'b0};
        tbl[6] = '{32'h0000_0405, 32'd3,         1'b1};
        tbl[7] = '{32'd5,         32'h0001_0002, 1'b1};
        tbl[8] = '{32'd3,         32'd479,       1'b0};

        reset_v    = '1;
        start      = 1'b0;
        data_ready = 1'b0;
        data       = '0;
        sel        = 2'd0;
        for (int k = 0; k < N_DUT; k++) exp_cnt[k] = 0;

        // Reset state of every instance
        #2;
        for (int k = 0; k < N_DUT; k++) begin
            sel = 2'(k);
            #1;
            check("rst_wanted", o_dw, 1);
            check("rst_we", o_we, 0);
            check("rst_loaded", o_ld, 0);
            check("rst_error", o_er, 0);
            check("rst_x", o_x, 0);
            check("rst_y", o_y, 0);
            check("rst_wmask", o_wm, 0);
            check("rst_frame_cnt", o_fc, 0);
        end
        next_cycle();
        reset_v = '0;

        // Header validation table
        sel = 2'd0;
        for (int i = 0; i < 9; i++) begin
            do_reset(0);
            data_ready = 1'b1;
            data       = tbl[i].w;
            next_cycle();
            data = tbl[i].h;
            next_cycle();
            data_ready = 1'b0;
            @(negedge clk);
            check("hdr_tbl_error", o_er, tbl[i].err);
            check("hdr_tbl_wanted", o_dw, !tbl[i].err);
            next_cycle();
        end

        // Rejected widths, error level and start recovery
        do_reset(0);
        data_ready = 1'b1;
        data       = 32'd0;
        next_cycle();
        repeat (2) begin
            @(negedge clk);
            check("err0_error", o_er, 1);
            check("err0_wanted", o_dw, 0);
            check("err0_we", o_we, 0);
            next_cycle();
        end
        data_ready = 1'b0;
        start      = 1'b1;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        check("err0_clear_error", o_er, 0);
        check("err0_clear_wanted", o_dw, 1);
        next_cycle();
        data_ready = 1'b1;
        data       = 32'd641;
        next_cycle();
        data_ready = 1'b0;
        @(negedge clk);
        check("err641_error", o_er, 1);
        check("err641_wanted", o_dw, 0);
        next_cycle();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        check("err641_clear", o_er, 0);
        next_cycle();

        // LANES=1 frames: continuous 4x3, gapped 5x5, single pixel
        run_frame(4, 3, 100);
        rearm();
        run_frame(5, 5, 50);
        rearm();
        run_frame(1, 1, 100);
        rearm();

        // Reset after 7 of 12 beats, then a clean frame
        send_header(4, 3, 100);
        data_ready = 1'b1;
        repeat (7) begin
            data = $urandom;
            next_cycle();
        end
        #1;
        check("mid_x", o_x, 3);
        check("mid_y", o_y, 1);
        #1;
        reset_v[0] = 1'b1;
        #1;
        exp_cnt[0] = 0;
        check("mid_rst_we", o_we, 0);
        check("mid_rst_x", o_x, 0);
        check("mid_rst_y", o_y, 0);
        check("mid_rst_wmask", o_wm, 0);
        check("mid_rst_loaded", o_ld, 0);
        check("mid_rst_error", o_er, 0);
        check("mid_rst_frame_cnt", o_fc, 0);
        check("mid_rst_wanted", o_dw, 1);
        data_ready = 1'b0;
        #1;
        reset_v[0] = 1'b0;
        next_cycle();
        run_frame(4, 3, 100);

        // LANES=4: ragged 10x2, full-width row, single-column tall frame, gapped
        sel = 2'd1;
        do_reset(1);
        run_frame(10, 2, 100);
        rearm();
        run_frame(640, 1, 100);
        rearm();
        run_frame(1, 480, 100);
        rearm();
        run_frame(7, 3, 50);

        // AUTO_REARM: three back-to-back 2x2 frames, loaded high one cycle each
        sel = 2'd2;
        do_reset(2);
        ar_mon = 1'b1;
        for (int f = 0; f < 3; f++) begin
            run_frame(2, 2, 100);
            @(negedge clk);
            check("ar_loaded_drop", o_ld, 0);
            check("ar_wanted", o_dw, 1);
            next_cycle();
        end
        ar_mon = 1'b0;
        check("ar_pulses", 64'(ld_pulses), 3);
        check("ar_frame_cnt", o_fc, 3);

        // LANES=2: random sizes and stall patterns
        sel = 2'd3;
        do_reset(3);
        for (int n = 0; n < 6; n++) begin
            run_frame(int'($urandom_range(1, 9)), int'($urandom_range(1, 4)), int'($urandom_range(30, 100)));
            rearm();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
